// File: rtl/led_pkg.sv
// ----------------------------------------------------------------------------
// led_pkg
// Shared constants for the LED column scanner front-end.
//   - Write-port address map (column bytes, commit strobe, brightness).
//   - FSM state encoding for the commit/swap controller.
//   - Number of scanned columns.
// ----------------------------------------------------------------------------
package led_pkg;

    localparam int NCOLS = 4;

    localparam logic [2:0] ADDR_COL0   = 3'd0;
    localparam logic [2:0] ADDR_COL1   = 3'd1;
    localparam logic [2:0] ADDR_COL2   = 3'd2;
    localparam logic [2:0] ADDR_COL3   = 3'd3;
    localparam logic [2:0] ADDR_COMMIT = 3'd4;
    localparam logic [2:0] ADDR_BRIGHT = 3'd5;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

endpackage

// File: rtl/led_frame_timer.sv
// ----------------------------------------------------------------------------
// led_frame_timer
// Free-running frame counter with a registered end-of-frame pulse. Shared
// with the scanner so both agree on where a frame starts.
// Ports:
//   clk        in   system clock
//   resetn     in   synchronous active-low reset
//   frame_tick out  1-cycle pulse, registered from (counter == all-ones)
// ----------------------------------------------------------------------------
module led_frame_timer #(
    parameter int FRAME_BITS = 18
) (
    input  logic clk,
    input  logic resetn,
    output logic frame_tick
);

    logic [FRAME_BITS-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt + 1'b1;
            frame_tick <= (cnt == '1);
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// ----------------------------------------------------------------------------
// led_scan_ctrl
// Double-buffered register front-end for the 4x8 LED column scanner. The CPU
// fills a back buffer through a valid/ready write port and then commits; the
// back buffer is copied to the front buffer only on a frame boundary, so a
// half-written image is never shown.
// Optional feature macro: LED_SCAN_CTRL_DIM_EN (brightness register + PWM
// gating of the column outputs).
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   wr_valid/ready   write handshake; accepted when both high
//   wr_addr/data     0-3 back column, 4 commit, 5 brightness, 6-7 ignored
//   busy             commit pending (waiting for frame boundary)
//   frame_tick       end-of-frame pulse
//   swap_done        pulse in the cycle after the front buffer updates
//   leds1..leds4     registered column bytes to the scanner
// ----------------------------------------------------------------------------
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int FRAME_BITS = 18,
    parameter int PWM_BITS   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       frame_tick,
    output logic       swap_done,
    output logic [7:0] leds1,
    output logic [7:0] leds2,
    output logic [7:0] leds3,
    output logic [7:0] leds4
);

    logic [0:0] state;
    logic [7:0] back_buf  [NCOLS];
    logic [7:0] front_buf [NCOLS];
    logic [7:0] leds_q    [NCOLS];
    logic       wr_fire;
    logic       pwm_lit;

    led_frame_timer #(
        .FRAME_BITS (FRAME_BITS)
    ) u_frame_timer (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick)
    );

    // Back buffer is frozen while a swap is pending by refusing writes.
    assign wr_ready = (state == ST_IDLE);
    assign busy     = (state == ST_PENDING);
    assign wr_fire  = wr_valid && wr_ready;

    // NOTE: the buffers are a handful of flops, not a RAM, so they are reset
    // explicitly; a reset during PENDING thus discards the queued image.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            swap_done <= 1'b0;
            for (int i = 0; i < NCOLS; i++) begin
                back_buf[i]  <= 8'h00;
                front_buf[i] <= 8'h00;
            end
        end else begin
            swap_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_fire) begin
                        if (!wr_addr[2]) begin
                            back_buf[wr_addr[1:0]] <= wr_data;
                        end else if (wr_addr == ADDR_COMMIT) begin
                            // A commit landing on a tick cycle waits for the
                            // following tick: PENDING is only entered here.
                            state <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (frame_tick) begin
                        for (int i = 0; i < NCOLS; i++) begin
                            front_buf[i] <= back_buf[i];
                        end
                        state     <= ST_IDLE;
                        swap_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LED_SCAN_CTRL_DIM_EN
    logic [PWM_BITS-1:0] brightness;
    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            brightness <= '1;
            pwm_cnt    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (wr_fire && (wr_addr == ADDR_BRIGHT)) begin
                brightness <= wr_data[PWM_BITS-1:0];
            end
        end
    end

    // Brightness b lights b+1 of 2**PWM_BITS phases; all-ones is always on.
    assign pwm_lit = (pwm_cnt <= brightness);
`else
    // No dimming: every phase is lit.
    assign pwm_lit = (PWM_BITS > 0);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NCOLS; i++) begin
                leds_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NCOLS; i++) begin
                leds_q[i] <= pwm_lit ? front_buf[i] : 8'h00;
            end
        end
    end

    assign leds1 = leds_q[0];
    assign leds2 = leds_q[1];
    assign leds3 = leds_q[2];
    assign leds4 = leds_q[3];

endmodule

// File: tb/tb_led_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_scan_ctrl
// Directed bench for led_scan_ctrl with FRAME_BITS = 4 (16-cycle frames).
// Committed images are queued as expected leds values and popped when the
// DUT reports swap_done.
// ----------------------------------------------------------------------------
module tb_led_scan_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_tick;
    logic       swap_done;
    logic [7:0] leds1, leds2, leds3, leds4;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] shown;
    logic [7:0]  back_model [4];

    led_scan_ctrl #(
        .FRAME_BITS (4),
        .PWM_BITS   (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_tick (frame_tick),
        .swap_done  (swap_done),
        .leds1      (leds1),
        .leds2      (leds2),
        .leds3      (leds3),
        .leds4      (leds4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] leds_all();
        return {leds1, leds2, leds3, leds4};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        bit ok;
        ok       = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 40; i++) begin
            if (wr_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("write_ready_timeout", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
        if (!a[2]) back_model[a[1:0]] = d;
    endtask

    task automatic commit();
        write(3'd4, 8'h00);
        exp_q.push_back({back_model[0], back_model[1], back_model[2], back_model[3]});
    endtask

    // Waits for swap_done, checking leds hold the old image meanwhile.
    // n returns the number of cycles busy was seen high before the pulse.
    task automatic wait_swap(input string tag, output int n);
        bit          seen;
        logic [31:0] exp;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 40; i++) begin
            if (swap_done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
            check({tag, "_hold"}, leds_all(), shown);
            step();
        end
        if (!seen) begin
            check({tag, "_swap_timeout"}, 32'(swap_done), 32'd1);
        end else begin
            step();
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
            end else begin
                exp = exp_q.pop_front();
                check({tag, "_leds"}, leds_all(), exp);
                shown = exp;
            end
            check({tag, "_swap_once"}, 32'(swap_done), 32'd0);
        end
    endtask

    initial begin
        int n;
        int lit;
        bit seen;

        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'h00;
        shown    = 32'h0;
        for (int i = 0; i < 4; i++) back_model[i] = 8'h00;

        // Reset held for 3 cycles.
        repeat (3) step();
        check("rst_leds",       leds_all(),         32'h0);
        check("rst_wr_ready",   32'(wr_ready),      32'd1);
        check("rst_busy",       32'(busy),          32'd0);
        check("rst_swap_done",  32'(swap_done),     32'd0);
        check("rst_frame_tick", 32'(frame_tick),    32'd0);
        resetn = 1'b1;
        step();

        // Fill back buffer and commit; leds hold 00 until the swap.
        write(3'd0, 8'hA5);
        write(3'd1, 8'h3C);
        write(3'd2, 8'h0F);
        write(3'd3, 8'hF0);
        check("pre_commit_leds", leds_all(), 32'h0);
        commit();
        check("commit_busy",     32'(busy),     32'd1);

        // Write attempted while pending is refused until the swap.
        wr_valid = 1'b1;
        wr_addr  = 3'd0;
        wr_data  = 8'hFF;
        check("pending_wr_ready", 32'(wr_ready), 32'd0);
        wait_swap("swap1", n);
        wr_valid = 1'b0;
        back_model[0] = 8'hFF;
        check("post_swap_busy",  32'(busy),     32'd0);
        step();
        check("late_write_hidden", 32'(leds1),  32'hA5);

        // Commit issued in a frame_tick cycle waits a full frame.
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) check("tick_timeout", 32'(frame_tick), 32'd1);
        commit();
        wait_swap("swap_on_tick", n);
        check("busy_cycles", 32'(n), 32'd16);

        // Reset during PENDING discards the swap.
        write(3'd2, 8'h55);
        commit();
        check("rst2_busy_before", 32'(busy), 32'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        void'(exp_q.pop_back());
        for (int i = 0; i < 4; i++) back_model[i] = 8'h00;
        shown = 32'h0;
        check("rst2_busy",     32'(busy),     32'd0);
        check("rst2_wr_ready", 32'(wr_ready), 32'd1);
        check("rst2_leds",     leds_all(),    32'h0);
        lit = 0;
        for (int i = 0; i < 40; i++) begin
            if (swap_done) lit++;
            if (leds_all() != 32'h0) lit++;
            step();
        end
        check("rst2_no_swap", 32'(lit), 32'd0);

        // Addresses 6/7 are accepted with no effect; front col0 = FF.
        write(3'd0, 8'hFF);
        write(3'd6, 8'h12);
        write(3'd7, 8'h34);
        check("addr67_ready", 32'(wr_ready), 32'd1);
        commit();
        wait_swap("swap_ff", n);

        // Brightness = 3.
        write(3'd5, 8'h03);
        step();
        lit = 0;
        for (int i = 0; i < 16; i++) begin
`ifdef LED_SCAN_CTRL_DIM_EN
            if (leds1 == 8'hFF) lit++;
            check("dim_leds1_level", 32'((leds1 == 8'hFF) || (leds1 == 8'h00)), 32'd1);
`else
            if (leds1 == 8'hFF) lit++;
            check("nodim_leds1", 32'(leds1), 32'hFF);
`endif
            check("dim_leds2", 32'(leds2), 32'h00);
            step();
        end
`ifdef LED_SCAN_CTRL_DIM_EN
        check("dim_lit_count", 32'(lit), 32'd4);
`else
        check("nodim_lit_count", 32'(lit), 32'd16);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
